// File: rtl/vend_pkg.sv
// Shared coin codes, coin values, dispense codes and state encoding for the
// vending-machine sequencing controller.
package vend_pkg;

   typedef enum logic [1:0] {
      NOCOIN  = 2'b00,
      NICKEL  = 2'b01,
      DIME    = 2'b10,
      QUARTER = 2'b11
   } coin_t;

   localparam logic [7:0] NICKEL_CENTS  = 8'd5;
   localparam logic [7:0] DIME_CENTS    = 8'd10;
   localparam logic [7:0] QUARTER_CENTS = 8'd25;

   // One-hot dispense codes indexed by change amount; bit 5 is never used.
   localparam logic [5:0] dispense   = 6'b000001;
   localparam logic [5:0] dispense5  = 6'b000010;
   localparam logic [5:0] dispense10 = 6'b000100;
   localparam logic [5:0] dispense15 = 6'b001000;
   localparam logic [5:0] dispense20 = 6'b010000;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      CHANGE,
      DISPENSE
   } state_t;

   function automatic logic [7:0] coin_value(input coin_t coin);
      case (coin)
         NICKEL:  return NICKEL_CENTS;
         DIME:    return DIME_CENTS;
         QUARTER: return QUARTER_CENTS;
         default: return 8'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_change_calc.sv
// Combinational change maker: splits a change amount into dimes first, then
// nickels, against the current inventory, and encodes the dispense code.
module vend_change_calc
   import vend_pkg::*;
(
   input  logic [7:0] change,
   input  logic [7:0] nickel_count,
   input  logic [7:0] dime_count,
   output logic [7:0] ndime,
   output logic [7:0] nnick,
   output logic       payable,
   output logic [5:0] code
);

   logic [7:0] dimes_wanted;
   logic [7:0] remainder;

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      dimes_wanted = change / 8'd10;
      ndime        = (dimes_wanted < dime_count) ? dimes_wanted : dime_count;
      remainder    = change - (8'd10 * ndime);
      nnick        = remainder / 8'd5;
      payable      = (nnick <= nickel_count);

      case (change)
         8'd0:    code = dispense;
         8'd5:    code = dispense5;
         8'd10:   code = dispense10;
         8'd15:   code = dispense15;
         8'd20:   code = dispense20;
         default: code = dispense;
      endcase
   end

endmodule

// File: rtl/vend_controller.sv
// Vending-machine sequencing controller: accepts coins, banks them into the
// coin counter, debits change from inventory and holds the dispense code.
module vend_controller
   import vend_pkg::*;
#(
   parameter int unsigned PRICE = 25
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [1:0] coin_in,
   input  logic       dispense_done,
   input  logic [7:0] nickelCount,
   input  logic [7:0] dimeCount,
   output logic       enable,
   output logic [1:0] coin_out,
   output logic [7:0] subNickel,
   output logic [7:0] subDime,
   output logic [5:0] dispenseReady,
   output logic [7:0] credit,
   output logic       busy,
   output logic       coin_reject
);

   localparam logic [7:0] PRICE_C = 8'(PRICE);

   state_t     state, state_d;
   logic [7:0] credit_d;
   coin_t      pend_coin, pend_coin_d;
   logic [7:0] pend_credit, pend_credit_d;
   logic [7:0] pend_nnick, pend_nnick_d;
   logic [7:0] pend_ndime, pend_ndime_d;
   logic [5:0] pend_code, pend_code_d;
   logic       reject_d;

   logic [7:0] coin_sum;
   logic [7:0] change_amt;
   logic [7:0] calc_ndime, calc_nnick;
   logic       calc_payable;
   logic [5:0] calc_code;

   // Change is evaluated against inventory before the triggering coin is banked.
   vend_change_calc u_change_calc (
      .change       (change_amt),
      .nickel_count (nickelCount),
      .dime_count   (dimeCount),
      .ndime        (calc_ndime),
      .nnick        (calc_nnick),
      .payable      (calc_payable),
      .code         (calc_code)
   );

   always_comb begin
      coin_sum      = credit + coin_value(coin_t'(coin_in));
      change_amt    = (coin_sum >= PRICE_C) ? (coin_sum - PRICE_C) : 8'd0;
      state_d       = state;
      credit_d      = credit;
      pend_coin_d   = pend_coin;
      pend_credit_d = pend_credit;
      pend_nnick_d  = pend_nnick;
      pend_ndime_d  = pend_ndime;
      pend_code_d   = pend_code;
      reject_d      = 1'b0;

      case (state)
         IDLE: begin
            if (coin_valid && (coin_in != NOCOIN)) begin
               if ((coin_sum < PRICE_C) || calc_payable) begin
                  state_d       = ACCEPT;
                  pend_coin_d   = coin_t'(coin_in);
                  pend_credit_d = coin_sum;
                  pend_nnick_d  = calc_nnick;
                  pend_ndime_d  = calc_ndime;
                  pend_code_d   = calc_code;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         ACCEPT: begin
            credit_d = pend_credit;
            state_d  = (pend_credit >= PRICE_C) ? CHANGE : IDLE;
         end
         CHANGE: begin
            state_d = DISPENSE;
         end
         DISPENSE: begin
            if (dispense_done) begin
               credit_d = 8'd0;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so each one lines up with the
   // cycle its state is occupied; debits are non-zero only in CHANGE.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         credit        <= 8'd0;
         pend_coin     <= NOCOIN;
         pend_credit   <= 8'd0;
         pend_nnick    <= 8'd0;
         pend_ndime    <= 8'd0;
         pend_code     <= 6'd0;
         enable        <= 1'b0;
         coin_out      <= NOCOIN;
         subNickel     <= 8'd0;
         subDime       <= 8'd0;
         dispenseReady <= 6'd0;
         busy          <= 1'b0;
         coin_reject   <= 1'b0;
      end else begin
         state         <= state_d;
         credit        <= credit_d;
         pend_coin     <= pend_coin_d;
         pend_credit   <= pend_credit_d;
         pend_nnick    <= pend_nnick_d;
         pend_ndime    <= pend_ndime_d;
         pend_code     <= pend_code_d;
         enable        <= (state_d == ACCEPT);
         coin_out      <= (state_d == ACCEPT) ? pend_coin_d : NOCOIN;
         subNickel     <= (state_d == CHANGE) ? pend_nnick_d : 8'd0;
         subDime       <= (state_d == CHANGE) ? pend_ndime_d : 8'd0;
         dispenseReady <= (state_d == DISPENSE) ? pend_code_d : 6'd0;
         busy          <= (state_d != IDLE);
         coin_reject   <= reject_d;
      end
   end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus randomized
// coin/inventory traffic compared against a transaction-level credit model.
module tb_vend_controller;

   localparam int PRICE = 25;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_in = 2'b00;
   logic       dispense_done = 1'b0;
   logic [7:0] nickelCount = 8'd0;
   logic [7:0] dimeCount = 8'd0;
   logic       enable;
   logic [1:0] coin_out;
   logic [7:0] subNickel;
   logic [7:0] subDime;
   logic [5:0] dispenseReady;
   logic [7:0] credit;
   logic       busy;
   logic       coin_reject;

   int         n_checks = 0;
   int         n_errors = 0;
   int         m_credit = 0;
   logic [5:0] m_code = 6'd0;

   always #5 clock = ~clock;

   vend_controller #(.PRICE(PRICE)) dut (
      .clock         (clock),
      .reset         (reset),
      .coin_valid    (coin_valid),
      .coin_in       (coin_in),
      .dispense_done (dispense_done),
      .nickelCount   (nickelCount),
      .dimeCount     (dimeCount),
      .enable        (enable),
      .coin_out      (coin_out),
      .subNickel     (subNickel),
      .subDime       (subDime),
      .dispenseReady (dispenseReady),
      .credit        (credit),
      .busy          (busy),
      .coin_reject   (coin_reject)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one cycle; debits must be zero on every cycle except CHANGE.
   task automatic step(input bit in_change);
      @(negedge clock);
      if (!in_change) check("sub_zero", {16'd0, subNickel, subDime}, 32'd0);
   endtask

   function automatic int cents(input logic [1:0] c);
      case (c)
         2'b01:   return 5;
         2'b10:   return 10;
         2'b11:   return 25;
         default: return 0;
      endcase
   endfunction

   task automatic set_inventory(input int nick, input int dime);
      nickelCount = 8'(nick);
      dimeCount   = 8'(dime);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_enable"}, enable, 0);
      check({tag, "_coin_out"}, coin_out, 0);
      check({tag, "_subNickel"}, subNickel, 0);
      check({tag, "_subDime"}, subDime, 0);
      check({tag, "_dispenseReady"}, dispenseReady, 0);
      check({tag, "_credit"}, credit, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_coin_reject"}, coin_reject, 0);
   endtask

   // Offer one coin in IDLE; returns with the DUT in IDLE or, if it vends, in DISPENSE.
   task automatic insert_coin(input logic [1:0] coin, output bit vended);
      int total, change, nd, nn;
      bit vend, ok;
      total  = m_credit + cents(coin);
      vend   = (coin != 2'b00) && (total >= PRICE);
      change = vend ? total - PRICE : 0;
      nd = 0;
      while (nd < int'(dimeCount) && (nd + 1) * 10 <= change) nd++;
      nn = (change - 10 * nd) / 5;
      ok = !vend || (nn <= int'(nickelCount));
      vended = 1'b0;

      coin_valid = 1'b1;
      coin_in    = coin;
      step(0);
      coin_valid = 1'b0;
      coin_in    = 2'b00;

      if (coin == 2'b00) begin
         check("nocoin_enable", {enable, coin_reject, busy}, 0);
         check("nocoin_credit", credit, m_credit);
         return;
      end
      if (!ok) begin
         check("rej_pulse", coin_reject, 1);
         check("rej_enable", enable, 0);
         check("rej_busy", busy, 0);
         check("rej_credit", credit, m_credit);
         step(0);
         check("rej_one_cycle", coin_reject, 0);
         check("rej_credit_hold", credit, m_credit);
         return;
      end

      check("acc_enable", enable, 1);
      check("acc_coin_out", coin_out, coin);
      check("acc_reject", coin_reject, 0);
      check("acc_busy", busy, 1);
      check("acc_credit_old", credit, m_credit);
      step(vend);
      check("post_enable", enable, 0);
      check("post_credit", credit, total);
      m_credit = total;
      if (!vend) begin
         check("post_busy", busy, 0);
         return;
      end

      check("chg_subNickel", subNickel, nn);
      check("chg_subDime", subDime, nd);
      check("chg_busy", busy, 1);
      check("chg_ready", dispenseReady, 0);
      m_code = 6'(1 << (change / 5));
      step(0);
      check("disp_code", dispenseReady, m_code);
      check("disp_busy", busy, 1);
      check("disp_credit", credit, total);
      vended = 1'b1;
   endtask

   // Hold in DISPENSE for some cycles (optionally offering an ignored coin), then acknowledge.
   task automatic finish_vend(input int hold, input bit poke);
      for (int i = 0; i < hold; i++) begin
         if (poke && i == 0) begin
            coin_valid = 1'b1;
            coin_in    = 2'b11;
         end
         step(0);
         coin_valid = 1'b0;
         coin_in    = 2'b00;
         check("hold_code", dispenseReady, m_code);
         check("hold_credit", credit, m_credit);
         check("hold_quiet", {enable, coin_reject, busy}, 1);
      end
      dispense_done = 1'b1;
      step(0);
      dispense_done = 1'b0;
      check("done_code", dispenseReady, 0);
      check("done_credit", credit, 0);
      check("done_busy", busy, 0);
      m_credit = 0;
   endtask

   task automatic idle_done_poke();
      dispense_done = 1'b1;
      step(0);
      dispense_done = 1'b0;
      check("idle_done_credit", credit, m_credit);
      check("idle_done_quiet", {dispenseReady, busy}, 0);
   endtask

   initial begin
      bit v;

      repeat (3) @(negedge clock);
      check_reset_outputs("rst");
      reset = 1'b1;
      step(0);

      // Exact price, change 0.
      set_inventory(4, 4);
      insert_coin(2'b11, v);
      check("t1_vended", v, 1);
      finish_vend(2, 0);

      // Dime, dime, quarter: change 20 paid as two dimes; coin ignored during DISPENSE.
      insert_coin(2'b10, v);
      insert_coin(2'b10, v);
      insert_coin(2'b11, v);
      check("t2_vended", v, 1);
      finish_vend(2, 1);

      // Short on dimes: change 20 as one dime and two nickels.
      set_inventory(2, 1);
      insert_coin(2'b10, v);
      insert_coin(2'b10, v);
      insert_coin(2'b11, v);
      check("t3_vended", v, 1);
      finish_vend(1, 0);

      // Unpayable change: quarter refused, then a nickel completes the sale.
      set_inventory(1, 0);
      insert_coin(2'b10, v);
      insert_coin(2'b10, v);
      insert_coin(2'b11, v);
      check("t4_rejected", v, 0);
      insert_coin(2'b01, v);
      check("t4_vended", v, 1);
      finish_vend(0, 0);

      // No-coin strobe and stray acknowledge in IDLE.
      insert_coin(2'b00, v);
      insert_coin(2'b01, v);
      idle_done_poke();
      insert_coin(2'b10, v);
      insert_coin(2'b10, v);
      check("t5_vended", v, 1);
      finish_vend(1, 0);

      // Reset during DISPENSE abandons the vend.
      set_inventory(4, 4);
      insert_coin(2'b11, v);
      reset = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      m_credit = 0;
      step(0);
      reset = 1'b1;
      step(0);
      insert_coin(2'b01, v);
      check("t6_credit5", credit, 5);

      // Randomized traffic against the transaction model.
      for (int it = 0; it < 300; it++) begin
         logic [1:0] c;
         if ($urandom_range(0, 3) == 0)
            set_inventory(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 15) == 0) idle_done_poke();
         c = 2'($urandom_range(0, 3));
         insert_coin(c, v);
         if (v) finish_vend(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
